imem_pair_loader: RTL and testbench

//  Upstream loader for the six-read/two-write instruction memory. Accepts a

---
 rtl/imem_pair_loader_if.sv | 37 +++
 rtl/imem_pair_loader.sv | 158 +++++++++++++++
 tb/tb_imem_pair_loader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_pair_loader_if.sv
//==============================================================================
// Module : imem_pair_loader_if
// Brief  : Word-stream and pair-write bus between the loader and its neighbours.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

interface imem_pair_loader_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] base_addr;
    logic [DATA_W-1:0] len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [DATA_W-1:0] addr_a;
    logic [DATA_W-1:0] addr_b;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic              we_a;
    logic              we_b;
    logic              busy;
    logic              done;

    modport master (
        output start, base_addr, len, in_valid, in_data,
        input  in_ready, addr_a, addr_b, data_a, data_b, we_a, we_b, busy, done
    );

    modport slave (
        input  start, base_addr, len, in_valid, in_data,
        output in_ready, addr_a, addr_b, data_a, data_b, we_a, we_b, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/imem_pair_loader.sv
//==============================================================================
// Module : imem_pair_loader
// Brief  : Packs a valid/ready word stream into even/odd pairs and writes each
//          pair in one cycle through the two memory write ports.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module imem_pair_loader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_pair_loader_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [DATA_W:0] c_DEPTH_X = (DATA_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] c_ONE   = DATA_W'(1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic [DATA_W-1:0] addr_a_q, addr_a_d;
    logic [DATA_W-1:0] addr_b_q, addr_b_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              we_a_q, we_a_d;
    logic              we_b_q, we_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              w_accept;

    // Addresses stay in [0, DEPTH), so one conditional subtract wraps them.
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] p,
                                                   input logic [1:0]        step);
        logic [DATA_W:0] sum;
        sum = {1'b0, p} + {{(DATA_W-1){1'b0}}, step};
        if (sum >= c_DEPTH_X) begin
            sum = sum - c_DEPTH_X;
        end
        return sum[DATA_W-1:0];
    endfunction

    assign bus.in_ready = (state_q == EVEN) || (state_q == ODD);
    assign w_accept     = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        rem_d    = rem_q;
        held_d   = held_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        we_a_d   = 1'b0;
        we_b_d   = 1'b0;
        busy_d   = busy_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                // busy is only high in IDLE during the done cycle, which also blocks start
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (bus.start) begin
                    ptr_d   = bus.base_addr;
                    rem_d   = bus.len;
                    busy_d  = 1'b1;
                    state_d = (bus.len == '0) ? FIN : EVEN;
                end
            end
            EVEN: begin
                if (w_accept) begin
                    held_d = bus.in_data;
                    rem_d  = rem_q - c_ONE;
                    if (rem_q == c_ONE) begin
                        we_a_d   = 1'b1;
                        addr_a_d = ptr_q;
                        data_a_d = bus.in_data;
                        state_d  = FIN;
                    end else begin
                        state_d  = ODD;
                    end
                end
            end
            ODD: begin
                if (w_accept) begin
                    we_a_d   = 1'b1;
                    we_b_d   = 1'b1;
                    addr_a_d = ptr_q;
                    addr_b_d = wrap_add(ptr_q, 2'd1);
                    data_a_d = held_q;
                    data_b_d = bus.in_data;
                    ptr_d    = wrap_add(ptr_q, 2'd2);
                    rem_d    = rem_q - c_ONE;
                    state_d  = (rem_q == c_ONE) ? FIN : EVEN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            rem_q    <= '0;
            held_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            data_a_q <= '0;
            data_b_q <= '0;
            we_a_q   <= 1'b0;
            we_b_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rem_q    <= rem_d;
            held_q   <= held_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            we_a_q   <= we_a_d;
            we_b_q   <= we_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.addr_a = addr_a_q;
    assign bus.addr_b = addr_b_q;
    assign bus.data_a = data_a_q;
    assign bus.data_b = data_b_q;
    assign bus.we_a   = we_a_q;
    assign bus.we_b   = we_b_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_pair_loader.sv
//==============================================================================
// Module : tb_imem_pair_loader
// Brief  : Directed self-checking bench for imem_pair_loader.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_imem_pair_loader;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    imem_pair_loader_if #(.DATA_W(DATA_W)) bus ();

    imem_pair_loader #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int       cyc;
        logic     wa;
        logic     wb;
        logic [7:0] aa;
        logic [7:0] da;
        logic [7:0] ab;
        logic [7:0] db;
    } wr_t;

    wr_t        wr_q[$];
    int         done_q[$];
    int         rdy_cnt;
    int         busy_cnt;
    logic [7:0] mem [256];

    // Passive capture of everything the DUT drives, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.we_a || bus.we_b) begin
            wr_q.push_back('{cyc, bus.we_a, bus.we_b, bus.addr_a, bus.data_a, bus.addr_b, bus.data_b});
            if (bus.we_a) mem[bus.addr_a] = bus.data_a;
            if (bus.we_b) mem[bus.addr_b] = bus.data_b;
        end
        if (bus.done)     done_q.push_back(cyc);
        if (bus.in_ready) rdy_cnt++;
        if (bus.busy)     busy_cnt++;
    end

    function automatic wr_t get_wr(int i);
        wr_t z;
        z = '{-1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
        if (i < wr_q.size()) return wr_q[i];
        return z;
    endfunction

    function automatic int get_done(int i);
        if (i < done_q.size()) return done_q[i];
        return -100;
    endfunction

    task automatic clear_log();
        wr_q.delete();
        done_q.delete();
        rdy_cnt  = 0;
        busy_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [7:0] base, input logic [7:0] len);
        bus.start     = 1'b1;
        bus.base_addr = base;
        bus.len       = len;
        tick(1);
        bus.start     = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        int t;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        t = 0;
        while (!bus.in_ready && t < 20) begin
            tick(1);
            t++;
        end
        n_tests++;
        if (t >= 20) begin
            n_fail++;
            $display("FAIL send_word_timeout: in_ready got 0 for %0d cycles, required 1", t);
        end
        tick(1);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({bus.in_ready, bus.we_a, bus.we_b, bus.busy, bus.done, bus.addr_a, bus.addr_b, bus.data_a, bus.data_b} !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b wa=%b wb=%b busy=%b done=%b aa=%h ab=%h da=%h db=%h, required all 0",
                     bus.in_ready, bus.we_a, bus.we_b, bus.busy, bus.done, bus.addr_a, bus.addr_b, bus.data_a, bus.data_b);
        end
    endtask

    task automatic test_even_len();
        wr_t e0, e1;
        clear_log();
        pulse_start(8'd0, 8'd4);
        send_word(8'd11); send_word(8'd22); send_word(8'd33); send_word(8'd44);
        tick(5);
        e0 = get_wr(0); e1 = get_wr(1);
        n_tests++;
        if (wr_q.size() !== 2) begin n_fail++; $display("FAIL even_len_writes: got %0d writes, required 2", wr_q.size()); end
        n_tests++;
        if ({e0.wa, e0.wb, e0.aa, e0.da, e0.ab, e0.db} !== {1'b1, 1'b1, 8'd0, 8'd11, 8'd1, 8'd22}) begin
            n_fail++; $display("FAIL even_len_pair0: got a%0d=%0d b%0d=%0d we=%b%b, required a0=11 b1=22 we=11", e0.aa, e0.da, e0.ab, e0.db, e0.wa, e0.wb);
        end
        n_tests++;
        if ({e1.wa, e1.wb, e1.aa, e1.da, e1.ab, e1.db} !== {1'b1, 1'b1, 8'd2, 8'd33, 8'd3, 8'd44}) begin
            n_fail++; $display("FAIL even_len_pair1: got a%0d=%0d b%0d=%0d we=%b%b, required a2=33 b3=44 we=11", e1.aa, e1.da, e1.ab, e1.db, e1.wa, e1.wb);
        end
        n_tests++;
        if (done_q.size() !== 1 || get_done(0) !== e1.cyc + 1) begin
            n_fail++; $display("FAIL even_len_done: got %0d pulses first at %0d, required 1 at %0d", done_q.size(), get_done(0), e1.cyc + 1);
        end
        n_tests++;
        if (busy_cnt !== 6 || rdy_cnt !== 4) begin
            n_fail++; $display("FAIL even_len_busy_ready: got busy=%0d ready=%0d cycles, required 6 and 4", busy_cnt, rdy_cnt);
        end
    endtask

    task automatic test_odd_tail();
        wr_t e0, e1;
        clear_log();
        pulse_start(8'd8, 8'd3);
        send_word(8'd5); send_word(8'd6); send_word(8'd7);
        tick(5);
        e0 = get_wr(0); e1 = get_wr(1);
        n_tests++;
        if (wr_q.size() !== 2 || {e0.wa, e0.wb, e0.aa, e0.da, e0.ab, e0.db} !== {1'b1, 1'b1, 8'd8, 8'd5, 8'd9, 8'd6}) begin
            n_fail++; $display("FAIL odd_tail_pair: got n=%0d a%0d=%0d b%0d=%0d we=%b%b, required n=2 a8=5 b9=6 we=11", wr_q.size(), e0.aa, e0.da, e0.ab, e0.db, e0.wa, e0.wb);
        end
        n_tests++;
        if ({e1.wa, e1.wb, e1.aa, e1.da} !== {1'b1, 1'b0, 8'd10, 8'd7}) begin
            n_fail++; $display("FAIL odd_tail_single: got a%0d=%0d we=%b%b, required a10=7 we=10", e1.aa, e1.da, e1.wa, e1.wb);
        end
        n_tests++;
        if (done_q.size() !== 1 || get_done(0) !== e1.cyc + 1 || busy_cnt !== 5) begin
            n_fail++; $display("FAIL odd_tail_done: got %0d pulses at %0d busy=%0d, required 1 at %0d busy=5", done_q.size(), get_done(0), busy_cnt, e1.cyc + 1);
        end
    endtask

    task automatic test_zero_len();
        clear_log();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        pulse_start(8'd3, 8'd0);
        tick(5);
        bus.in_valid = 1'b0;
        n_tests++;
        if (wr_q.size() !== 0 || rdy_cnt !== 0) begin
            n_fail++; $display("FAIL zero_len_quiet: got writes=%0d ready=%0d, required 0 and 0", wr_q.size(), rdy_cnt);
        end
        n_tests++;
        if (done_q.size() !== 1 || busy_cnt !== 2) begin
            n_fail++; $display("FAIL zero_len_done: got done=%0d busy=%0d, required 1 and 2", done_q.size(), busy_cnt);
        end
    endtask

    task automatic test_wrap();
        wr_t e0, e1;
        clear_log();
        pulse_start(8'(DEPTH - 1), 8'd4);
        send_word(8'hA1); send_word(8'hB2); send_word(8'hC3); send_word(8'hD4);
        tick(5);
        e0 = get_wr(0); e1 = get_wr(1);
        n_tests++;
        if ({e0.wa, e0.wb, e0.aa, e0.da, e0.ab, e0.db} !== {1'b1, 1'b1, 8'd15, 8'hA1, 8'd0, 8'hB2}) begin
            n_fail++; $display("FAIL wrap_pair0: got a%0d=%h b%0d=%h we=%b%b, required a15=a1 b0=b2 we=11", e0.aa, e0.da, e0.ab, e0.db, e0.wa, e0.wb);
        end
        n_tests++;
        if ({e1.wa, e1.wb, e1.aa, e1.da, e1.ab, e1.db} !== {1'b1, 1'b1, 8'd1, 8'hC3, 8'd2, 8'hD4}) begin
            n_fail++; $display("FAIL wrap_pair1: got a%0d=%h b%0d=%h we=%b%b, required a1=c3 b2=d4 we=11", e1.aa, e1.da, e1.ab, e1.db, e1.wa, e1.wb);
        end
    endtask

    task automatic test_stall_and_restart_ignored();
        wr_t e0;
        clear_log();
        pulse_start(8'd0, 8'd4);
        send_word(8'd11);
        tick(1);
        pulse_start(8'd5, 8'd1);
        tick(1);
        send_word(8'd22); send_word(8'd33); send_word(8'd44);
        tick(8);
        e0 = get_wr(0);
        n_tests++;
        if (wr_q.size() !== 2 || {mem[0], mem[1], mem[2], mem[3], mem[5]} !== {8'd11, 8'd22, 8'd33, 8'd44, 8'd0}) begin
            n_fail++; $display("FAIL stall_contents: got n=%0d mem0..3=%0d,%0d,%0d,%0d mem5=%0d, required n=2 11,22,33,44 mem5=0",
                               wr_q.size(), mem[0], mem[1], mem[2], mem[3], mem[5]);
        end
        n_tests++;
        if (rdy_cnt !== 7 || busy_cnt !== 9 || done_q.size() !== 1 || e0.aa !== 8'd0) begin
            n_fail++; $display("FAIL stall_timing: got ready=%0d busy=%0d done=%0d aa0=%0d, required 7 9 1 0", rdy_cnt, busy_cnt, done_q.size(), e0.aa);
        end
    endtask

    task automatic test_reset_mid_load();
        wr_t e0;
        clear_log();
        pulse_start(8'd0, 8'd4);
        send_word(8'h11);
        rst = 1'b1;
        #2;
        test_reset();
        tick(1);
        rst = 1'b0;
        tick(4);
        n_tests++;
        if (wr_q.size() !== 0 || done_q.size() !== 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: got writes=%0d done=%0d, required 0 and 0", wr_q.size(), done_q.size());
        end
        clear_log();
        pulse_start(8'd4, 8'd2);
        send_word(8'h21); send_word(8'h22);
        tick(4);
        e0 = get_wr(0);
        n_tests++;
        if (wr_q.size() !== 1 || {e0.wa, e0.wb, e0.aa, e0.da, e0.ab, e0.db} !== {1'b1, 1'b1, 8'd4, 8'h21, 8'd5, 8'h22} || done_q.size() !== 1) begin
            n_fail++; $display("FAIL reset_mid_reload: got n=%0d a%0d=%h b%0d=%h done=%0d, required n=1 a4=21 b5=22 done=1",
                               wr_q.size(), e0.aa, e0.da, e0.ab, e0.db, done_q.size());
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        clear_log();
        tick(3);
        test_reset();
        rst = 1'b0;
        tick(2);
        test_reset();
        test_even_len();
        test_odd_tail();
        test_zero_len();
        test_wrap();
        test_stall_and_restart_ignored();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
